// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-write bundle shared between the requesters, the arbiter and the FIFO write port.
// The slave modport is the arbiter's view; master is the requester/FIFO environment.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       fifo_full;
  logic                       fifo_write_en;
  logic [DATA_W-1:0]          fifo_write_data;
  logic                       grant_valid;
  logic [$clog2(NUM_REQ)-1:0] grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_write_en, fifo_write_data, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_write_en, fifo_write_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Grants last up to MAX_BURST beats or until last; one IDLE bubble separates grants.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  fifo_write_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [0:0]      state_q,      state_d;
  logic [ID_W-1:0] grant_id_q,   grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;
  logic              release_gnt;
  logic [ID_W:0]     pick;
  logic [NUM_REQ-1:0] ready;

  // Returns {found, index}: first valid requester above 'last', wrapping.
  // Walking the offsets downward lets the smallest offset overwrite the rest.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    xfer        = (state_q == GRANT) && sel_valid && !bus.fifo_full;
    release_gnt = (state_q == GRANT) &&
                  ((xfer && (sel_last || (beat_cnt_q == CNT_MAX))) || !sel_valid);
    pick        = rr_pick(bus.req_valid, last_grant_q);
    ready       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = xfer && (grant_id_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          grant_id_d = pick[ID_W-1:0];
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // A full FIFO only freezes the burst; it never forces a release.
        if (release_gnt) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      grant_id_q   <= LAST_ID;
      last_grant_q <= LAST_ID;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.req_ready       = ready;
  assign bus.fifo_write_en   = xfer;
  assign bus.fifo_write_data = sel_data;
  assign bus.grant_valid     = (state_q == GRANT);
  assign bus.grant_id        = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: requester queues drive beats, a scoreboard
// holds the hand-ordered expected FIFO writes and a negedge monitor checks them.
module tb_fifo_write_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_l;
  int   nchecks = 0;
  int   nerrors = 0;

  logic [8:0]         rq [NUM_REQ][$];
  logic [NUM_REQ-1:0] en;
  exp_t               sb [$];

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int id, input logic [7:0] data, input logic last);
    rq[id].push_back({last, data});
  endtask

  task automatic expect_wr(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0) || (bus.grant_valid === 1'b1);
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy() && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    tick();
  endtask

  task automatic reset_pulse(input string name);
    rst_l = 1'b0;
    tick(2);
    chk({name, "_rst_grant_valid"}, {31'd0, bus.grant_valid}, 32'd0);
    chk({name, "_rst_write_en"},    {31'd0, bus.fifo_write_en}, 32'd0);
    chk({name, "_rst_ready"},       {28'd0, bus.req_ready}, 32'd0);
    chk({name, "_rst_grant_id"},    {30'd0, bus.grant_id}, 32'd3);
    rst_l = 1'b1;
  endtask

  // Requester model: sample acceptance at negedge, retire/present beats just after posedge.
  initial begin
    logic [NUM_REQ-1:0] acc;
    logic [8:0] h;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          h = rq[i][0];
          bus.req_valid[i] = en[i];
          bus.req_data[i*DATA_W +: DATA_W] = h[7:0];
          bus.req_last[i] = h[8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i*DATA_W +: DATA_W] = '0;
          bus.req_last[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (rst_l === 1'b1) begin
        if (bus.fifo_write_en === 1'b1) begin
          if (sb.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_write: got data 0x%0h id %0d expected no write at %0t",
                     bus.fifo_write_data, bus.grant_id, $time);
          end else begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.id;
            chk("wr_id",    {30'd0, bus.grant_id}, {30'd0, e.id});
            chk("wr_data",  {24'd0, bus.fifo_write_data}, {24'd0, e.data});
            chk("wr_ready", {28'd0, bus.req_ready}, {28'd0, oh});
          end
        end else begin
          chk("no_wr_ready", {28'd0, bus.req_ready}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ord [5];
    ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_l = 1'b0;
    bus.fifo_full = 1'b0;
    en = '1;
    reset_pulse("init");

    // Single requester, 3 beats.
    tick();
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    expect_wr(2, 8'hA1); expect_wr(2, 8'hA2); expect_wr(2, 8'hA3);
    tick();
    chk("t1_grant_valid", {31'd0, bus.grant_valid}, 32'd1);
    chk("t1_grant_id",    {30'd0, bus.grant_id}, 32'd2);
    tick(3);
    chk("t1_released",    {31'd0, bus.grant_valid}, 32'd0);
    wait_idle("t1");

    // Round robin with single-beat bursts.
    reset_pulse("t2");
    for (int i = 0; i < NUM_REQ; i++) load(i, 8'hB0 + 8'(i), 1'b1);
    load(0, 8'hB4, 1'b1);
    for (int i = 0; i < 5; i++) expect_wr(ord[i], 8'hB0 + 8'(i));
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t2_grant_valid", {31'd0, bus.grant_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) chk("t2_grant_id", {30'd0, bus.grant_id}, {30'd0, ord[(i-1)/2]});
    end
    wait_idle("t2");

    // Burst cap interleaves requester 3.
    for (int i = 1; i <= 6; i++) load(1, 8'hC0 + 8'(i), i == 6);
    load(3, 8'hD1, 1'b1);
    for (int i = 1; i <= 4; i++) expect_wr(1, 8'hC0 + 8'(i));
    expect_wr(3, 8'hD1);
    expect_wr(1, 8'hC5); expect_wr(1, 8'hC6);
    tick();
    chk("t3_first_grant", {30'd0, bus.grant_id}, 32'd1);
    tick(5);
    chk("t3_cap_grant_valid", {31'd0, bus.grant_valid}, 32'd1);
    chk("t3_cap_grant_id",    {30'd0, bus.grant_id}, 32'd3);
    wait_idle("t3");

    // Backpressure mid-burst.
    for (int i = 1; i <= 4; i++) begin
      load(0, 8'hE0 + 8'(i), i == 4);
      expect_wr(0, 8'hE0 + 8'(i));
    end
    tick(3);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t4_full_write_en",    {31'd0, bus.fifo_write_en}, 32'd0);
      chk("t4_full_ready",       {28'd0, bus.req_ready}, 32'd0);
      chk("t4_full_grant_valid", {31'd0, bus.grant_valid}, 32'd1);
      chk("t4_full_grant_id",    {30'd0, bus.grant_id}, 32'd0);
      tick();
    end
    bus.fifo_full = 1'b0;
    wait_idle("t4");

    // Granted requester drops valid before its first beat.
    load(2, 8'hF1, 1'b1);
    tick();
    chk("t5_grant_valid", {31'd0, bus.grant_valid}, 32'd1);
    chk("t5_grant_id",    {30'd0, bus.grant_id}, 32'd2);
    en[2] = 1'b0;
    load(1, 8'h61, 1'b1);
    load(3, 8'h63, 1'b1);
    expect_wr(3, 8'h63); expect_wr(1, 8'h61); expect_wr(2, 8'hF1);
    tick();
    chk("t5_drop_release", {31'd0, bus.grant_valid}, 32'd0);
    tick();
    chk("t5_next_valid", {31'd0, bus.grant_valid}, 32'd1);
    chk("t5_next_id",    {30'd0, bus.grant_id}, 32'd3);
    en[2] = 1'b1;
    wait_idle("t5");

    // Reset during beat 2 of requester 1.
    for (int i = 1; i <= 4; i++) load(1, 8'h70 + 8'(i), i == 4);
    expect_wr(1, 8'h71);
    tick();
    chk("t6_grant_id", {30'd0, bus.grant_id}, 32'd1);
    tick();
    #2;
    rst_l = 1'b0;
    #1;
    chk("t6_rst_write_en",    {31'd0, bus.fifo_write_en}, 32'd0);
    chk("t6_rst_grant_valid", {31'd0, bus.grant_valid}, 32'd0);
    chk("t6_rst_grant_id",    {30'd0, bus.grant_id}, 32'd3);
    chk("t6_rst_ready",       {28'd0, bus.req_ready}, 32'd0);
    load(0, 8'h81, 1'b1);
    expect_wr(0, 8'h81);
    expect_wr(1, 8'h72); expect_wr(1, 8'h73); expect_wr(1, 8'h74);
    tick(2);
    rst_l = 1'b1;
    tick();
    chk("t6_post_rst_valid", {31'd0, bus.grant_valid}, 32'd1);
    chk("t6_post_rst_id",    {30'd0, bus.grant_id}, 32'd0);
    wait_idle("t6");

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
